// File: rtl/acc_seq_pkg.sv
// Shared opcodes, FSM state encoding and decode helpers for the accumulator sequencer.
// Optional retired-instruction counter in the top is enabled by ACC_SEQ_RETIRE_CNT_EN.
package acc_seq_pkg;

    localparam int OPC_W = 4;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP   = 4'h0,
        OP_LOAD  = 4'h1,
        OP_STORE = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_AND   = 4'h5,
        OP_OR    = 4'h6,
        OP_XOR   = 4'h7,
        OP_JMP   = 4'h8,
        OP_JZ    = 4'h9,
        OP_SHL   = 4'hA,
        OP_SHR   = 4'hB,
        OP_HALT  = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        MEM_RD,
        MEM_WR,
        HALTED,
        ERROR
    } state_e;

    // Opcodes that read an operand from memory and combine it with AC.
    function automatic logic is_alu_mem_op(input logic [OPC_W-1:0] opc);
        case (opc)
            OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/acc_seq_alu.sv
// Combinational accumulator ALU for the memory-operand instructions; LOAD passes the operand.
module acc_seq_alu
    import acc_seq_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [OPC_W-1:0]  opcode,
    input  logic [DATA_W-1:0] ac,
    input  logic [DATA_W-1:0] operand,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = operand;
        case (opcode)
            OP_ADD:  result = ac + operand;
            OP_SUB:  result = ac - operand;
            OP_AND:  result = ac & operand;
            OP_OR:   result = ac | operand;
            OP_XOR:  result = ac ^ operand;
            default: result = operand;
        endcase
    end

endmodule

// File: rtl/acc_sequencer.sv
// Fetch/decode/execute controller for the accumulator machine with a req/ack memory port.
// Define ACC_SEQ_RETIRE_CNT_EN to add the 32-bit retired-instruction counter output.
//
// state  | meaning
// FETCH  | read instruction at pc, wait for ack
// DECODE | one cycle: jumps, shifts, operand address capture
// MEM_RD | read operand at mar, update ac on ack
// MEM_WR | write ac to mar, wait for ack
// HALTED | idle until resume pulse
// ERROR  | illegal opcode seen, idle until reset
module acc_sequencer
    import acc_seq_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 12,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              resume,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ac,
    output logic [DATA_W-1:0] ir,
    output logic              halted,
    output logic              error
`ifdef ACC_SEQ_RETIRE_CNT_EN
    ,
    output logic [31:0]       retired
`endif
);

    state_e            state, state_nxt;
    logic [ADDR_W-1:0] mar;
    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] addr_field;
    logic [DATA_W-1:0] alu_result;
    logic              req_int;

    assign opcode     = ir[DATA_W-1 -: OPC_W];
    assign addr_field = ir[ADDR_W-1:0];

    generate
        if (DATA_W > OPC_W + ADDR_W) begin : g_ir_gap
            logic unused_ir_gap;
            assign unused_ir_gap = ^ir[DATA_W-OPC_W-1:ADDR_W];
        end
    endgenerate

    acc_seq_alu #(.DATA_W(DATA_W)) u_alu (
        .opcode  (opcode),
        .ac      (ac),
        .operand (mem_rdata),
        .result  (alu_result)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= FETCH;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_int   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = mar;
        mem_wdata = ac;
        case (state)
            FETCH: begin
                req_int  = 1'b1;
                mem_addr = pc;
                if (mem_ack) state_nxt = DECODE;
            end
            DECODE: begin
                if (is_alu_mem_op(opcode)) begin
                    state_nxt = MEM_RD;
                end else begin
                    case (opcode)
                        OP_STORE:                               state_nxt = MEM_WR;
                        OP_NOP, OP_JMP, OP_JZ, OP_SHL, OP_SHR:  state_nxt = FETCH;
                        OP_HALT:                                state_nxt = HALTED;
                        default:                                state_nxt = ERROR;
                    endcase
                end
            end
            MEM_RD: begin
                req_int = 1'b1;
                if (mem_ack) state_nxt = FETCH;
            end
            MEM_WR: begin
                req_int = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) state_nxt = FETCH;
            end
            HALTED: begin
                if (resume) state_nxt = FETCH;
            end
            ERROR:   state_nxt = ERROR;
            default: state_nxt = ERROR;
        endcase
    end

    // Request is forced low while reset is held so an in-flight access is abandoned at once.
    assign mem_req = req_int & reset_n;
    assign halted  = (state == HALTED);
    assign error   = (state == ERROR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc  <= ADDR_W'(RESET_PC);
            ac  <= '0;
            ir  <= '0;
            mar <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ack) begin
                        ir <= mem_rdata;
                        pc <= pc + ADDR_W'(1);
                    end
                end
                DECODE: begin
                    case (opcode)
                        OP_JMP: pc <= addr_field;
                        OP_JZ:  if (ac == '0) pc <= addr_field;
                        OP_SHL: ac <= ac << 1;
                        OP_SHR: ac <= ac >> 1;
                        default: begin
                            if (is_alu_mem_op(opcode) || opcode == OP_STORE) mar <= addr_field;
                        end
                    endcase
                end
                MEM_RD: begin
                    if (mem_ack) ac <= alu_result;
                end
                default: ;
            endcase
        end
    end

`ifdef ACC_SEQ_RETIRE_CNT_EN
    // An instruction retires when it leaves its last execution state for FETCH or HALTED.
    logic retire;
    assign retire = (state == DECODE || state == MEM_RD || state == MEM_WR) &&
                    (state_nxt == FETCH || state_nxt == HALTED);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    retired <= '0;
        else if (retire) retired <= retired + 32'd1;
    end
`endif

endmodule
